// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS datapath: data/register-address widths, the
// hardwired zero register, and register numbers that control logic names.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // $zero is a constant, not storage.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Registers with fixed roles in the calling convention.
    localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_reg_file_reg_word.sv
// ---------------------------------------------------------------------------
// reg_word
// One register-file word: a W-bit flip-flop with load enable and an
// asynchronous active-high clear. The clear dominates, so a load presented
// while rst_i is high never lands.
//
// Ports:
//   clk_i  in   rising-edge clock
//   rst_i  in   async active-high clear
//   en_i   in   load enable, sampled on the rising edge
//   d_i    in   W-bit load value
//   q_o    out  W-bit stored value
// ---------------------------------------------------------------------------
module reg_word
    import mips_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (en_i) begin
            word_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule : reg_word

// File: rtl/mips_reg_file.sv
// ---------------------------------------------------------------------------
// mips_reg_file
// 32 x 32-bit MIPS general-purpose register file feeding the ALU operands.
// Two combinational read ports, one synchronous write port, $0 hardwired to
// zero, optional same-cycle write-to-read bypass.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   async active-high reset, clears every register
//   wr_en     in   write enable
//   wr_addr   in   destination register (ADDR_W)
//   wr_data   in   value to write (DATA_W)
//   rd_addr1  in   read port 1 address (rs)
//   rd_addr2  in   read port 2 address (rt)
//   rd_data1  out  read port 1 data, ALU operand A
//   rd_data2  out  read port 2 data, ALU operand B
// ---------------------------------------------------------------------------
module mips_reg_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(mips_pkg::REG_ZERO);

    // Stored words; entry 0 is the constant zero register.
    logic [DATA_W-1:0] regs [NREGS];

    // A write is live when enabled and not aimed at $0. Reset gating is left
    // to the storage (clear dominates) and to the read path below.
    logic wr_live;
    assign wr_live = wr_en && (wr_addr != ZERO_ADDR);

    assign regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_word
        logic word_we;
        assign word_we = wr_live && (wr_addr == ADDR_W'(i));

        reg_word #(
            .W (DATA_W)
        ) u_word (
            .clk_i (clk),
            .rst_i (rst),
            .en_i  (word_we),
            .d_i   (wr_data),
            .q_o   (regs[i])
        );
    end

    // Per-port bypass compare. Suppressed during reset so outputs read zero
    // for every address while rst is high.
    logic byp1;
    logic byp2;
    assign byp1 = BYPASS && !rst && wr_live && (wr_addr == rd_addr1);
    assign byp2 = BYPASS && !rst && wr_live && (wr_addr == rd_addr2);

    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (rst) begin
            rd_data1 = '0;
            rd_data2 = '0;
        end else begin
            if (byp1) rd_data1 = wr_data;
            if (byp2) rd_data2 = wr_data;
        end
    end

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// ---------------------------------------------------------------------------
// tb_mips_reg_file
// Drives one BYPASS=1 and one BYPASS=0 register file from the same inputs.
// Inputs change on the falling clock edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_mips_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

    mips_reg_file #(.BYPASS(1'b1)) u_dut_byp (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd1_b),
        .rd_data2 (rd2_b)
    );

    mips_reg_file #(.BYPASS(1'b0)) u_dut_nob (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd1_n),
        .rd_data2 (rd2_n)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_mem [32];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [DW-1:0] e1b, input logic [DW-1:0] e2b,
                           input logic [DW-1:0] e1n, input logic [DW-1:0] e2n);
        chk({name, " byp rd1"}, rd1_b, e1b);
        chk({name, " byp rd2"}, rd2_b, e2b);
        chk({name, " nob rd1"}, rd1_n, e1n);
        chk({name, " nob rd2"}, rd2_n, e2n);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = ra1;
        rd_addr2 = ra2;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1b;   // expected before the edge, BYPASS=1
        logic [DW-1:0] e2b;
        logic [DW-1:0] e1n;   // expected before the edge, BYPASS=0
        logic [DW-1:0] e2n;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd4,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd4,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h00000011, 5'd5,  5'd7,  32'hDEADBEEF, 32'h00000011, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h00000011, 32'h00000011};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[7]  = '{1'b1, 5'd31, 32'h0000FFFF, 5'd31, 5'd29, 32'h0000FFFF, 32'h0,        32'h0,        32'h0};
        vecs[8]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd31, 32'hA5A5A5A5, 32'h0000FFFF, 32'h0,        32'h0000FFFF};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF};
        vecs[10] = '{1'b1, 5'd2,  32'h80000001, 5'd1,  5'd2,  32'h0,        32'h80000001, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd5,  32'h80000001, 32'hDEADBEEF, 32'h80000001, 32'hDEADBEEF};

        for (int i = 0; i < 32; i++) exp_mem[i] = '0;

        // Reads during reset: zero everywhere, bypass included.
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, AW'(a), 32'hFFFFFFFF, AW'(a), AW'(31 - a));
            #1;
            chk_all($sformatf("in_reset a%0d", a), '0, '0, '0, '0);
        end

        @(negedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0);
        rst = 1'b0;

        // Post-reset sweep.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, '0, '0, AW'(a), AW'(31 - a));
            #1;
            chk_all($sformatf("post_reset a%0d", a), '0, '0, '0, '0);
        end

        // Table vectors: check before the edge, let the edge commit.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e1b, vecs[i].e2b, vecs[i].e1n, vecs[i].e2n);
            if (vecs[i].we && vecs[i].wa != 0) exp_mem[vecs[i].wa] = vecs[i].wd;
        end

        // Reset pulse between edges clears state immediately.
        @(negedge clk);
        drive(1'b0, '0, '0, 5'd3, 5'd31);
        #1;
        chk_all("pre_pulse", 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h11112222, 5'd3, 5'd31);
        #1;
        chk_all("in_pulse", '0, '0, '0, '0);
        #2;
        rst = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        #1;
        chk_all("after_pulse", '0, '0, '0, '0);

        // Write presented across an edge while reset is held is dropped.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h11112222, 5'd3, 5'd3);
        @(posedge clk);
        #1;
        chk_all("held_rst_edge", '0, '0, '0, '0);

        // First edge with reset low writes normally.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h5555AAAA, 5'd3, 5'd3);
        #1;
        chk_all("first_wr_pre", 32'h5555AAAA, 32'h5555AAAA, '0, '0);
        exp_mem[3] = 32'h5555AAAA;
        @(negedge clk);
        drive(1'b0, '0, '0, 5'd3, 5'd3);
        #1;
        chk_all("first_wr_post", 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA);

        // r10..r12 on back-to-back edges, port 1 trailing one address behind.
        exp_q.push_back(exp_mem[9]);
        for (int k = 0; k < 3; k++) begin
            logic [DW-1:0] v;
            logic [DW-1:0] e;
            v = 32'h0A0B0C00 + DW'(k);
            @(negedge clk);
            drive(1'b1, AW'(10 + k), v, AW'(9 + k), 5'd13);
            #1;
            e = exp_q.pop_front();
            chk_all($sformatf("seq k%0d", k), e, '0, e, '0);
            exp_q.push_back(v);
            exp_mem[10 + k] = v;
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 5'd12, 5'd13);
        #1;
        chk_all("seq tail", exp_q.pop_front(), '0, 32'h0A0B0C02, '0);

        // Full sweep against the model: nothing else moved.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, '0, '0, AW'(a), AW'(31 - a));
            #1;
            chk_all($sformatf("final a%0d", a), exp_mem[a], exp_mem[31 - a], exp_mem[a], exp_mem[31 - a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mips_reg_file
